// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline-priority merge of long-latency results onto the RF port.
// Define WB_ARBITER_BYPASS_EN to register an empty-FIFO result straight onto rgf_*.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wn,
    input  logic [31:0] pipe_data,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_rd,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        hazard,
    output logic [31:0] busy,
    output logic        rgf_we,
    output logic [4:0]  rgf_wn,
    output logic [31:0] rgf_data
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   busy_q, busy_d, clr_mask, set_mask;
    logic          rgf_we_q, rgf_we_d;
    logic [4:0]    rgf_wn_q, rgf_wn_d;
    logic [31:0]   rgf_data_q, rgf_data_d;
    logic          accept, push, pop, bypass, sel_valid;

    assign lu_ready = (cnt_q != (AW+1)'(FIFO_DEPTH)) && !rst;
    assign busy     = busy_q;
    assign rgf_we   = rgf_we_q;
    assign rgf_wn   = rgf_wn_q;
    assign rgf_data = rgf_data_q;

    assign hazard = ((dec_rs1 != 5'd0) && busy_q[dec_rs1])
                  | ((dec_rs2 != 5'd0) && busy_q[dec_rs2])
                  | ((dec_rd  != 5'd0) && busy_q[dec_rd]);

    always_comb begin
        accept = lu_valid && lu_ready;
        pop    = !pipe_we && (cnt_q != '0);
`ifdef WB_ARBITER_BYPASS_EN
        bypass = accept && !pipe_we && (cnt_q == '0);
`else
        bypass = 1'b0;
`endif
        push       = accept && !bypass;
        sel_valid  = 1'b0;
        rgf_wn_d   = '0;
        rgf_data_d = '0;
        clr_mask   = '0;
        set_mask   = '0;
        if (pipe_we) begin
            sel_valid  = 1'b1;
            rgf_wn_d   = pipe_wn;
            rgf_data_d = pipe_data;
        end else if (pop) begin
            sel_valid  = 1'b1;
            rgf_wn_d   = fifo_rd_q[rptr_q];
            rgf_data_d = fifo_data_q[rptr_q];
            clr_mask[fifo_rd_q[rptr_q]] = 1'b1;
        end else if (bypass) begin
            sel_valid  = 1'b1;
            rgf_wn_d   = lu_rd;
            rgf_data_d = lu_data;
            clr_mask[lu_rd] = 1'b1;
        end
        rgf_we_d = sel_valid && (rgf_wn_d != 5'd0);
        if (lu_issue) set_mask[lu_issue_rd] = 1'b1;
        // set applied after clear so a same-cycle reissue keeps the bit
        busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
        if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= '0;
            rgf_we_q   <= 1'b0;
            rgf_wn_q   <= '0;
            rgf_data_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rgf_we_q   <= rgf_we_d;
            rgf_wn_q   <= rgf_wn_d;
            rgf_data_q <= rgf_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= lu_rd;
            fifo_data_q[wptr_q] <= lu_data;
        end
    end
endmodule
